// File: rtl/pcpu_pkg.sv
// Shared pipeline types for the memory port arbiter.
// DMType codes, arbiter FSM states and port owners.
package pcpu_pkg;

    localparam logic [2:0] DM_WORD   = 3'b000;
    localparam logic [2:0] DM_HALF   = 3'b001;
    localparam logic [2:0] DM_HALF_U = 3'b010;
    localparam logic [2:0] DM_BYTE   = 3'b011;
    localparam logic [2:0] DM_BYTE_U = 3'b100;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_MEM
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side bundle of the memory port arbiter.
// master = IF/MEM stages, slave = arbiter.
interface mem_port_arbiter_if #(
    parameter int AW = 32
) ();

    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_flush;
    logic [31:0]   if_rdata;
    logic          if_ready;
    logic          mem_rd;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [2:0]    mem_dmtype;
    logic [31:0]   mem_rdata;
    logic          mem_ready;
    logic          mem_misalign;
    logic          stall_if;
    logic          stall_mem;

    modport master (
        output if_req, if_addr, if_flush,
        output mem_rd, mem_wr, mem_addr, mem_wdata, mem_dmtype,
        input  if_rdata, if_ready,
        input  mem_rdata, mem_ready, mem_misalign,
        input  stall_if, stall_mem
    );

    modport slave (
        input  if_req, if_addr, if_flush,
        input  mem_rd, mem_wr, mem_addr, mem_wdata, mem_dmtype,
        output if_rdata, if_ready,
        output mem_rdata, mem_ready, mem_misalign,
        output stall_if, stall_mem
    );

endinterface

// File: rtl/dm_align.sv
// Byte-lane steering for stores, lane select and extension for loads.
// Also flags half/word accesses that cross their natural alignment.
module dm_align
    import pcpu_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [2:0]  dmtype,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  we,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    logic        is_half;
    logic        is_byte;
    logic        sgn;
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        is_half = (dmtype == DM_HALF) || (dmtype == DM_HALF_U);
        is_byte = (dmtype == DM_BYTE) || (dmtype == DM_BYTE_U);
        sgn     = (dmtype == DM_HALF) || (dmtype == DM_BYTE);
        b       = rdata[7:0];
        unique case (addr)
            2'd0: b = rdata[7:0];
            2'd1: b = rdata[15:8];
            2'd2: b = rdata[23:16];
            2'd3: b = rdata[31:24];
        endcase
        h = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    // Unknown DMType codes fall through to the word defaults.
    always_comb begin
        we         = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rdata;
        misalign   = (addr != 2'b00);
        unique case (1'b1)
            is_half: begin
                we         = addr[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = {{16{sgn & h[15]}}, h};
                misalign   = addr[0];
            end
            is_byte: begin
                we         = 4'b0001 << addr;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = {{24{sgn & b[7]}}, b};
                misalign   = 1'b0;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port RAM between IF and MEM.
// MEM has fixed priority; IF fetches can be dropped by a flush.
module mem_port_arbiter
    import pcpu_pkg::*;
#(
    parameter int RAM_LAT = 1,
    parameter int AW      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.slave    bus,
    output logic                 ram_en,
    output logic [3:0]           ram_we,
    output logic [AW-1:0]        ram_addr,
    output logic [31:0]          ram_wdata,
    input  logic [31:0]          ram_rdata
);

    arb_state_t    state_q, state_d;
    owner_t        owner_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [2:0]    type_q;
    logic          wr_q;
    logic          mis_q;
    logic          drop_q;
    logic [3:0]    cnt_q;
    logic [31:0]   data_q;
    logic [31:0]   if_hold_q;
    logic [31:0]   mem_hold_q;

    logic          mem_go;
    logic          if_go;
    logic          ld_done;
    logic [1:0]    al_addr;
    logic [2:0]    al_type;
    logic [3:0]    al_we;
    logic [31:0]   al_wdata;
    logic [31:0]   al_rdata;
    logic          al_mis;

    assign mem_go = bus.mem_rd | bus.mem_wr;
    assign if_go  = bus.if_req & ~bus.if_flush;

    // In IDLE the aligner looks at the live request to catch misalignment.
    assign al_addr = (state_q == IDLE) ? bus.mem_addr[1:0] : addr_q[1:0];
    assign al_type = (state_q == IDLE) ? bus.mem_dmtype : type_q;

    dm_align u_align (
        .addr       (al_addr),
        .dmtype     (al_type),
        .wdata      (wdata_q),
        .rdata      (ram_rdata),
        .we         (al_we),
        .wdata_lane (al_wdata),
        .rdata_ext  (al_rdata),
        .misalign   (al_mis)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (mem_go)
                    state_d = al_mis ? DONE : ISSUE;
                else if (if_go)
                    state_d = ISSUE;
            end
            ISSUE: state_d = wr_q ? DONE : WAIT;
            WAIT:  if (cnt_q == 4'd1) state_d = DONE;
            DONE:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            addr_q     <= '0;
            wdata_q    <= '0;
            type_q     <= DM_WORD;
            wr_q       <= 1'b0;
            mis_q      <= 1'b0;
            drop_q     <= 1'b0;
            cnt_q      <= '0;
            data_q     <= '0;
            if_hold_q  <= '0;
            mem_hold_q <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (mem_go) begin
                        owner_q <= OWN_MEM;
                        addr_q  <= bus.mem_addr;
                        wdata_q <= bus.mem_wdata;
                        type_q  <= bus.mem_dmtype;
                        wr_q    <= bus.mem_wr;
                        mis_q   <= al_mis;
                        data_q  <= '0;
                        drop_q  <= 1'b0;
                    end else if (if_go) begin
                        owner_q <= OWN_IF;
                        addr_q  <= bus.if_addr;
                        type_q  <= DM_WORD;
                        wr_q    <= 1'b0;
                        mis_q   <= 1'b0;
                        drop_q  <= 1'b0;
                    end
                end
                ISSUE: cnt_q <= 4'(RAM_LAT);
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1)
                        data_q <= (owner_q == OWN_MEM) ? al_rdata : ram_rdata;
                end
                DONE: begin
                    if (bus.if_ready) if_hold_q <= data_q;
                    if (ld_done)      mem_hold_q <= data_q;
                end
            endcase
            if (state_q != IDLE && owner_q == OWN_IF && bus.if_flush)
                drop_q <= 1'b1;
        end
    end

    assign bus.if_ready = (state_q == DONE) && (owner_q == OWN_IF)
                          && !drop_q && !bus.if_flush;
    assign bus.mem_ready    = (state_q == DONE) && (owner_q == OWN_MEM);
    assign bus.mem_misalign = bus.mem_ready & mis_q;
    assign ld_done          = bus.mem_ready & (~wr_q | mis_q);

    // Read data is shown live during DONE, then held until the next completion.
    assign bus.if_rdata  = bus.if_ready ? data_q : if_hold_q;
    assign bus.mem_rdata = ld_done ? data_q : mem_hold_q;

    assign bus.stall_if  = bus.if_req & ~bus.if_ready;
    assign bus.stall_mem = mem_go & ~bus.mem_ready;

    assign ram_en    = (state_q == ISSUE);
    assign ram_we    = (ram_en & wr_q) ? al_we : 4'b0000;
    assign ram_addr  = ram_en ? {addr_q[AW-1:2], 2'b00} : '0;
    assign ram_wdata = (ram_en & wr_q) ? al_wdata : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: one arbiter at RAM_LAT=1, one at RAM_LAT=3.
// Each has a small behavioural RAM with the matching read latency.
module tb_mem_port_arbiter;
    import pcpu_pkg::*;

    logic clk;
    logic rst;

    int checks = 0;
    int errs   = 0;

    mem_port_arbiter_if #(.AW(32)) b1 ();
    mem_port_arbiter_if #(.AW(32)) b3 ();

    logic        en1, en3;
    logic [3:0]  we1, we3;
    logic [31:0] a1, a3, wd1, wd3, rd1, rd3;

    mem_port_arbiter #(.RAM_LAT(1), .AW(32)) u1 (
        .clk(clk), .rst(rst), .bus(b1),
        .ram_en(en1), .ram_we(we1), .ram_addr(a1),
        .ram_wdata(wd1), .ram_rdata(rd1)
    );

    mem_port_arbiter #(.RAM_LAT(3), .AW(32)) u3 (
        .clk(clk), .rst(rst), .bus(b3),
        .ram_en(en3), .ram_we(we3), .ram_addr(a3),
        .ram_wdata(wd3), .ram_rdata(rd3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] m1 [0:255];
    logic [31:0] m3 [0:255];
    logic [31:0] p3_0, p3_1;
    int          en3_n = 0;

    always @(posedge clk) begin
        if (rst) begin
            m1[64]  <= 32'h00A00093;
            m1[65]  <= 32'h00100113;
            m1[128] <= 32'hDEADBEEF;
            m1[129] <= 32'h00000000;
        end else if (en1) begin
            for (int i = 0; i < 4; i++)
                if (we1[i]) m1[a1[9:2]][8*i +: 8] <= wd1[8*i +: 8];
        end
        rd1 <= en1 ? m1[a1[9:2]] : 32'hBAD0BAD0;
    end

    // Three-stage read pipe; deliberately not reset.
    always @(posedge clk) begin
        if (rst) begin
            m3[16] <= 32'h12345678;
            m3[17] <= 32'hCAFEF00D;
            m3[18] <= 32'h0BADC0DE;
            m3[19] <= 32'h55AA33CC;
        end
        p3_0 <= en3 ? m3[a3[9:2]] : 32'hBAD0BAD0;
        p3_1 <= p3_0;
        rd3  <= p3_1;
        if (en3) en3_n <= en3_n + 1;
    end

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic ld1(input logic [31:0] a, input logic [2:0] dm,
                       input logic [31:0] exp, input string tag);
        nxt;
        b1.mem_rd = 1'b1; b1.mem_addr = a; b1.mem_dmtype = dm;
        repeat (3) nxt;
        #1;
        chk({tag, "_rdy"}, 32'(b1.mem_ready), 32'd1);
        chk(tag, b1.mem_rdata, exp);
        nxt;
        b1.mem_rd = 1'b0;
    endtask

    int e0;

    initial begin
        rst = 1'b1;
        b1.if_req = 0; b1.if_addr = 0; b1.if_flush = 0;
        b1.mem_rd = 0; b1.mem_wr = 0; b1.mem_addr = 0;
        b1.mem_wdata = 0; b1.mem_dmtype = 0;
        b3.if_req = 0; b3.if_addr = 0; b3.if_flush = 0;
        b3.mem_rd = 0; b3.mem_wr = 0; b3.mem_addr = 0;
        b3.mem_wdata = 0; b3.mem_dmtype = 0;
        nxt; nxt;
        #1;
        chk("rst_if_ready", 32'(b1.if_ready), 0);
        chk("rst_mem_ready", 32'(b1.mem_ready), 0);
        chk("rst_ram_en", 32'(en1), 0);
        chk("rst_stall", 32'({b1.stall_if, b1.stall_mem}), 0);
        chk("rst_if_rdata", b1.if_rdata, 0);
        chk("rst_state3", 32'(u3.state_q), 32'(IDLE));
        nxt;
        rst = 1'b0;

        // Fetch at RAM_LAT=1
        nxt;
        b1.if_req = 1'b1; b1.if_addr = 32'h100;
        #1;
        chk("f_stall_t0", 32'(b1.stall_if), 1);
        chk("f_en_t0", 32'(en1), 0);
        nxt;
        chk("f_en_t1", 32'(en1), 1);
        chk("f_addr_t1", a1, 32'h100);
        chk("f_we_t1", 32'(we1), 0);
        nxt;
        chk("f_stall_t2", 32'(b1.stall_if), 1);
        chk("f_rdy_t2", 32'(b1.if_ready), 0);
        nxt;
        chk("f_rdy_t3", 32'(b1.if_ready), 1);
        chk("f_data_t3", b1.if_rdata, 32'h00A00093);
        chk("f_stall_t3", 32'(b1.stall_if), 0);
        nxt;
        b1.if_req = 1'b0;
        #1;
        chk("f_rdy_t4", 32'(b1.if_ready), 0);
        chk("f_hold_t4", b1.if_rdata, 32'h00A00093);

        // Simultaneous IF and MEM requests
        nxt;
        b1.if_req = 1'b1; b1.if_addr = 32'h104;
        b1.mem_rd = 1'b1; b1.mem_addr = 32'h200; b1.mem_dmtype = DM_WORD;
        #1;
        chk("s_stall_mem_t0", 32'(b1.stall_mem), 1);
        nxt;
        chk("s_addr_t1", a1, 32'h200);
        nxt;
        nxt;
        chk("s_mrdy_t3", 32'(b1.mem_ready), 1);
        chk("s_mdata_t3", b1.mem_rdata, 32'hDEADBEEF);
        chk("s_stall_if_t3", 32'(b1.stall_if), 1);
        nxt;
        b1.mem_rd = 1'b0;
        #1;
        chk("s_stall_if_t4", 32'(b1.stall_if), 1);
        chk("s_mhold_t4", b1.mem_rdata, 32'hDEADBEEF);
        nxt;
        chk("s_en_t5", 32'(en1), 1);
        chk("s_addr_t5", a1, 32'h104);
        nxt;
        nxt;
        chk("s_irdy_t7", 32'(b1.if_ready), 1);
        chk("s_idata_t7", b1.if_rdata, 32'h00100113);
        nxt;
        b1.if_req = 1'b0;

        // Store byte, then load it back several ways
        nxt;
        b1.mem_wr = 1'b1; b1.mem_addr = 32'h203;
        b1.mem_wdata = 32'h000000A5; b1.mem_dmtype = DM_BYTE;
        nxt;
        chk("sb_en", 32'(en1), 1);
        chk("sb_we", 32'(we1), 32'b1000);
        chk("sb_wdata", wd1, 32'hA5A5A5A5);
        nxt;
        chk("sb_rdy", 32'(b1.mem_ready), 1);
        chk("sb_mis", 32'(b1.mem_misalign), 0);
        chk("sb_rdata_held", b1.mem_rdata, 32'hDEADBEEF);
        nxt;
        b1.mem_wr = 1'b0;
        ld1(32'h203, DM_BYTE,   32'hFFFFFFA5, "lb");
        ld1(32'h203, DM_BYTE_U, 32'h000000A5, "lbu");
        ld1(32'h202, DM_HALF_U, 32'h0000A5AD, "lhu");
        ld1(32'h202, DM_HALF,   32'hFFFFA5AD, "lh");

        // Store half into the upper lanes
        nxt;
        b1.mem_wr = 1'b1; b1.mem_addr = 32'h206;
        b1.mem_wdata = 32'h00001234; b1.mem_dmtype = DM_HALF;
        nxt;
        chk("sh_we", 32'(we1), 32'b1100);
        chk("sh_wdata", wd1, 32'h12341234);
        nxt;
        chk("sh_rdy", 32'(b1.mem_ready), 1);
        nxt;
        b1.mem_wr = 1'b0;
        ld1(32'h204, DM_WORD, 32'h12340000, "lw_after_sh");

        // Misaligned word load
        nxt;
        b1.mem_rd = 1'b1; b1.mem_addr = 32'h202; b1.mem_dmtype = DM_WORD;
        #1;
        chk("mis_en_t0", 32'(en1), 0);
        nxt;
        chk("mis_rdy", 32'(b1.mem_ready), 1);
        chk("mis_flag", 32'(b1.mem_misalign), 1);
        chk("mis_rdata", b1.mem_rdata, 0);
        chk("mis_en_t1", 32'(en1), 0);
        nxt;
        b1.mem_rd = 1'b0;

        // Flush during WAIT at RAM_LAT=3
        nxt;
        b3.if_req = 1'b1; b3.if_addr = 32'h40;
        e0 = en3_n;
        nxt;
        nxt;
        nxt;
        b3.if_flush = 1'b1; b3.if_req = 1'b0;
        #1;
        chk("fl_rdy_t3", 32'(b3.if_ready), 0);
        nxt;
        b3.if_flush = 1'b0;
        #1;
        chk("fl_rdy_t4", 32'(b3.if_ready), 0);
        nxt;
        chk("fl_state_t5", 32'(u3.state_q), 32'(DONE));
        chk("fl_rdy_t5", 32'(b3.if_ready), 0);
        chk("fl_rdata_t5", b3.if_rdata, 0);
        chk("fl_en_cnt", 32'(en3_n - e0), 1);
        nxt;
        b3.if_req = 1'b1; b3.if_addr = 32'h44;
        repeat (4) nxt;
        chk("fl2_rdy_t10", 32'(b3.if_ready), 0);
        nxt;
        chk("fl2_rdy_t11", 32'(b3.if_ready), 1);
        chk("fl2_data", b3.if_rdata, 32'hCAFEF00D);
        nxt;
        b3.if_req = 1'b0;

        // Reset in the middle of a read
        nxt;
        b3.mem_rd = 1'b1; b3.mem_addr = 32'h48; b3.mem_dmtype = DM_WORD;
        nxt;
        nxt;
        rst = 1'b1; b3.mem_rd = 1'b0;
        nxt;
        rst = 1'b0;
        #1;
        chk("rr_state", 32'(u3.state_q), 32'(IDLE));
        chk("rr_mrdy", 32'(b3.mem_ready), 0);
        chk("rr_mrdata", b3.mem_rdata, 0);
        chk("rr_irdata", b3.if_rdata, 0);
        chk("rr_en", 32'(en3), 0);
        nxt;
        chk("rr_late_rdy", 32'(b3.mem_ready), 0);
        chk("rr_late_rdata", b3.mem_rdata, 0);
        nxt;
        b3.mem_rd = 1'b1; b3.mem_addr = 32'h4C; b3.mem_dmtype = DM_WORD;
        repeat (5) nxt;
        chk("rr_new_rdy", 32'(b3.mem_ready), 1);
        chk("rr_new_data", b3.mem_rdata, 32'h55AA33CC);
        nxt;
        b3.mem_rd = 1'b0;
        nxt;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, word-wide, fixed-latency RAM between the pipeline's instruction-fetch (IF) port and data-access (MEM) port.
- Sequences each access through an arbitration FSM.
- Performs byte-lane steering for stores and sign/zero extension for loads, using the DMType encoding produced by ctrl.
- Drives the stall signals that freeze the IF and MEM pipeline stages while an access is outstanding.

Parameters:
- RAM_LAT, 1, cycles from the ram_en cycle to the cycle in which ram_rdata is valid; legal range 1..15.
- AW, 32, address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- if_req  in  1  fetch request; held with stable if_addr until if_ready
- if_addr  in  AW  fetch byte address
- if_flush  in  1  discard the in-flight fetch (taken branch or jump)
- if_rdata  out  32  fetched instruction
- if_ready  out  1  one-cycle completion pulse for a fetch
- mem_rd  in  1  load request (MemRead); held until mem_ready
- mem_wr  in  1  store request (MemWrite); held until mem_ready
- mem_addr  in  AW  data byte address
- mem_wdata  in  32  store data, right-aligned
- mem_dmtype  in  3  DMType
- mem_rdata  out  32  extended load data
- mem_ready  out  1  one-cycle completion pulse for a data access
- mem_misalign  out  1  pulses together with mem_ready when the access was misaligned
- stall_if  out  1  if_req & ~if_ready
- stall_mem  out  1  (mem_rd|mem_wr) & ~mem_ready
- ram_en  out  1  RAM access strobe, one cycle per access
- ram_we  out  4  byte write enables; 0 for reads
- ram_addr  out  AW  word address, {addr[AW-1:2],2'b00}
- ram_wdata  out  32  lane-steered store data
- ram_rdata  in  32  RAM read data

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: FSM=IDLE; all outputs 0; counter and drop flag cleared. Reset mid-access abandons the RAM transaction, and any later ram_rdata is ignored.
- DMType encoding: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned. Any other value is treated as word.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE arbitration:
  - If mem_rd|mem_wr is high, grant MEM (fixed priority; MEM is the older instruction).
  - Otherwise, if if_req & ~if_flush, grant IF.
  - Grant registers the address, data, type and owner, then the FSM moves to ISSUE.
  - mem_rd and mem_wr both high: treated as a store.
- Misalignment: a MEM access with half and addr[0]=1, or word and addr[1:0]!=0, goes IDLE->DONE directly. No ram_en. mem_rdata=0, mem_misalign=1.
- ISSUE:
  - ram_en=1 for exactly this cycle.
  - Store: ram_we is set from the lanes (byte: 1<<addr[1:0]; half: 0011 or 1100; word: 1111), data is replicated into those lanes, and the FSM goes to DONE.
  - Read: ram_we=0, the counter loads RAM_LAT, and the FSM goes to WAIT.
- WAIT: the counter decrements each cycle. In the cycle the counter reaches 1, ram_rdata is captured (lane-selected and extended for MEM) and the FSM goes to DONE.
- DONE: the owner's ready output is 1 for this cycle only. Requests are not sampled in DONE; the FSM returns to IDLE.
- Latency from the IDLE cycle that sees the request (cycle t):
  - Read: ready at t+2+RAM_LAT (t+3 when RAM_LAT=1).
  - Store: ready at t+2.
  - Misaligned: ready at t+1.
- Request rule: requesters hold the request and its operands until their ready pulse. A request still high in the cycle after DONE is treated as a new transaction.
- Flush:
  - if_flush while the IF owner is in ISSUE, WAIT or DONE sets the drop flag. if_ready is then suppressed (forced 0 even in DONE) and if_rdata is unchanged.
  - The RAM read still completes, so the FSM timing is unchanged.
  - if_flush in IDLE blocks the IF grant that cycle; MEM remains eligible.
- Held data: if_rdata and mem_rdata hold their value until the next completion of their own port.
- Stalls are combinational from registered state. With no request pending, both stall outputs are 0.

Decomposition:
- Shared package pcpu_pkg:
  - DMType constants: DM_WORD, DM_HALF, DM_HALF_U, DM_BYTE, DM_BYTE_U.
  - FSM state typedef.
  - Owner enum: OWN_IF, OWN_MEM.
- Sub-module dm_align (combinational):
  - Inputs: addr[1:0], dmtype, wdata, rdata.
  - Outputs: we[3:0], steered wdata, extended rdata, misalign.
  - Instantiated once in mem_port_arbiter.

Test Plan:
- Fetch at RAM_LAT=1: if_req=1 with if_addr=0x100; RAM word at 0x100 = 0x00A00093 -> ram_en at t+1 with ram_addr=0x100; if_ready=1 at t+3 with if_rdata=0x00A00093; stall_if=1 during t..t+2.
- Simultaneous requests: if_req and mem_rd (word at 0x200 = 0xDEADBEEF) both high at t -> MEM served first with mem_ready at t+3 and mem_rdata=0xDEADBEEF; IF is granted at t+4 with if_ready at t+7; stall_if stays 1 throughout.
- Store byte and load back: sb with 0x000000A5 to 0x203 -> ram_we=1000, ram_wdata=0xA5A5A5A5, mem_ready at t+2. A following lb from 0x203 returns 0xFFFFFFA5; lbu returns 0x000000A5; lhu from 0x202 returns 0x0000A5xx, with xx the RAM's byte at 0x202.
- Misaligned access: lw at 0x202 -> no ram_en; mem_ready and mem_misalign both 1 at t+1; mem_rdata=0.
- Flush: RAM_LAT=3 fetch; if_flush pulses in the second WAIT cycle -> ram_en still issued once, FSM reaches DONE at t+5, if_ready stays 0; a new if_req at t+6 is served normally.
- Reset mid-read: rst high during WAIT -> next cycle all outputs 0 and FSM=IDLE; the late ram_rdata is ignored; a new request after reset completes with correct data.
